// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller for an asynchronous program ROM, with a
// debug read port that shares the ROM and can steal a slot after starving.
module rom_fetch_ctrl #(
  parameter logic [7:0] RESET_PC   = 8'd0,
  parameter int         STARVE_MAX = 4,
  parameter int         DATA_W     = 35
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [7:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [7:0]        instr_pc,
  output logic              instr_valid,
  input  logic              cpu_ready,
  input  logic              jump_en,
  input  logic [7:0]        jump_addr,
  input  logic              halt,
  input  logic              dbg_req,
  input  logic [7:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state;
  logic [7:0]         pc_p0;
  logic [2:0]         starve_cnt;
  logic [DATA_W-1:0]  instr_p1;
  logic [7:0]         instr_pc_p1;
  logic               vld_p1;
  logic [DATA_W-1:0]  dbg_data_p1;
  logic               dbg_vld_p1;

  logic fetch_slot;
  logic starved;
  logic grant;
  logic jump_take;
  logic consume;
  logic fetch;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Stage p0: slot arbitration and combinational ROM address
  always_comb begin
    consume    = vld_p1 && cpu_ready;
    jump_take  = jump_en && consume;
    fetch_slot = (state == RUN) && !halt && (!vld_p1 || cpu_ready);
    starved    = int'({29'd0, starve_cnt}) >= STARVE_MAX;
    grant      = dbg_req && !dbg_vld_p1 && (!fetch_slot || starved);
    fetch      = fetch_slot && !grant;
    if (grant)
      rom_addr = dbg_addr;
    else if (jump_take)
      rom_addr = jump_addr;
    else
      rom_addr = pc_p0;
  end

  // Stage p1: registered instruction, debug data and control state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      pc_p0       <= RESET_PC;
      starve_cnt  <= 3'd0;
      instr_p1    <= '0;
      instr_pc_p1 <= 8'd0;
      vld_p1      <= 1'b0;
      dbg_data_p1 <= '0;
      dbg_vld_p1  <= 1'b0;
    end else begin
      state <= halt ? HALTED : RUN;

      if (fetch) begin
        // A jump shows up here through rom_addr, giving a zero-bubble redirect
        instr_p1    <= rom_data;
        instr_pc_p1 <= rom_addr;
        vld_p1      <= 1'b1;
        pc_p0       <= rom_addr + 8'd1;
      end else if (jump_take) begin
        pc_p0  <= jump_addr;
        vld_p1 <= 1'b0;
      end else if (consume) begin
        vld_p1 <= 1'b0;
      end

      if (grant) begin
        dbg_data_p1 <= rom_data;
        dbg_vld_p1  <= 1'b1;
      end else begin
        dbg_vld_p1  <= 1'b0;
      end

      // Count only cycles where the request was eligible but lost the slot
      if (grant || !dbg_req)
        starve_cnt <= 3'd0;
      else if (!dbg_vld_p1)
        starve_cnt <= sat_inc3(starve_cnt);
    end
  end

  assign instr       = instr_p1;
  assign instr_pc    = instr_pc_p1;
  assign instr_valid = vld_p1;
  assign dbg_data    = dbg_data_p1;
  assign dbg_valid   = dbg_vld_p1;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Vector-table bench for rom_fetch_ctrl: expected records are queued as
// stimulus is driven and compared once the clock edge has produced outputs.
module tb_rom_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rom_addr;
  logic [34:0] rom_data;
  logic [34:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        cpu_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = 8'd0;
  logic        halt = 1'b0;
  logic        dbg_req = 1'b0;
  logic [7:0]  dbg_addr = 8'd0;
  logic [34:0] dbg_data;
  logic        dbg_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       cr;
    logic       je;
    logic [7:0] ja;
    logic       h;
    logic       dr;
    logic [7:0] da;
    logic [7:0] exp_addr;
    logic       exp_iv;
    logic [7:0] exp_ipc;
    logic       exp_dv;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rom_fetch_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .cpu_ready   (cpu_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_valid   (dbg_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [34:0] rom_word(input logic [7:0] a);
    return {a[2:0], a ^ 8'h5A, ~a, a, a + 8'd77};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  function automatic vec_t mk(input logic cr, input logic je, input logic [7:0] ja,
                              input logic h, input logic dr, input logic [7:0] da,
                              input logic [7:0] ea, input logic eiv,
                              input logic [7:0] eipc, input logic edv);
    vec_t v;
    v.cr = cr; v.je = je; v.ja = ja; v.h = h; v.dr = dr; v.da = da;
    v.exp_addr = ea; v.exp_iv = eiv; v.exp_ipc = eipc; v.exp_dv = edv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clock);
    cpu_ready = v.cr;
    jump_en   = v.je;
    jump_addr = v.ja;
    halt      = v.h;
    dbg_req   = v.dr;
    dbg_addr  = v.da;
    #1;
    chk("rom_addr", 64'(rom_addr), 64'(v.exp_addr));
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("instr_valid", 64'(instr_valid), 64'(e.exp_iv));
    if (e.exp_iv) begin
      chk("instr_pc", 64'(instr_pc), 64'(e.exp_ipc));
      chk("instr", 64'(instr), 64'(rom_word(e.exp_ipc)));
    end
    chk("dbg_valid", 64'(dbg_valid), 64'(e.exp_dv));
    if (e.exp_dv)
      chk("dbg_data", 64'(dbg_data), 64'(rom_word(e.da)));
  endtask

  initial begin
    // Streaming from reset, then a 3-cycle stall at instr_pc=4
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 1,   0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'(i), 1, 8'(i), 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 1, 4, 0));
    for (int i = 5; i <= 12; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'(i), 1, 8'(i), 0));
    // Zero-bubble jump, then wrap from 255 to 0
    vecs.push_back(mk(1, 1, 20,  0, 0, 0,  20, 1,  20, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  21, 1,  21, 0));
    vecs.push_back(mk(1, 1, 255, 0, 0, 0, 255, 1, 255, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,   0, 1,   0, 0));
    // Debug starved by 4 fetches, then steals one slot
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(1, 0, 0, 0, 1, 16, 8'(i), 1, 8'(i), 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16, 16, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   5, 1, 5, 0));

    cpu_ready = 1'b1;
    #1;
    chk("reset_instr_valid", 64'(instr_valid), 64'd0);
    chk("reset_instr_pc", 64'(instr_pc), 64'd0);
    chk("reset_instr", 64'(instr), 64'd0);
    chk("reset_dbg_valid", 64'(dbg_valid), 64'd0);
    chk("reset_rom_addr", 64'(rom_addr), 64'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Halt: consume and stop; debug granted immediately, no back-to-back grants
    apply(mk(1, 0, 0, 1, 0, 0,   6, 0, 0, 0));
    apply(mk(1, 0, 0, 1, 1, 40, 40, 0, 0, 1));
    apply(mk(1, 0, 0, 1, 1, 41,  6, 0, 0, 0));
    apply(mk(1, 0, 0, 1, 1, 41, 41, 0, 0, 1));
    apply(mk(1, 0, 0, 0, 0, 0,   6, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0,   6, 1, 6, 0));

    // Jump taken while halting redirects pc without fetching
    apply(mk(1, 1, 100, 1, 0, 0, 100, 0,   0, 0));
    apply(mk(1, 0, 0,   0, 0, 0, 100, 0,   0, 0));
    apply(mk(1, 0, 0,   0, 0, 0, 100, 1, 100, 0));

    // Asynchronous reset mid-stream, then restart at RESET_PC
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_instr_valid", 64'(instr_valid), 64'd0);
    chk("midrst_instr_pc", 64'(instr_pc), 64'd0);
    chk("midrst_instr", 64'(instr), 64'd0);
    chk("midrst_dbg_data", 64'(dbg_data), 64'd0);
    chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0: PC value loaded on reset.
REQ-002 SHALL have parameter STARVE_MAX, default 4: the number of consecutive denied debug cycles before debug steals a ROM slot.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rom_addr, output, 8: address to the asynchronous program ROM (combinational).
REQ-006 SHALL have port rom_data, input, 35: ROM word, valid in the same cycle as rom_addr.
REQ-007 SHALL have port instr, output, 35: registered instruction presented to the CPU.
REQ-008 SHALL have port instr_pc, output, 8: address that instr was fetched from.
REQ-009 SHALL have port instr_valid, output, 1: instr holds an unconsumed instruction.
REQ-010 SHALL have port cpu_ready, input, 1: the CPU consumes instr this cycle when instr_valid=1.
REQ-011 SHALL have port jump_en, input, 1: the consumed instruction redirects fetch; qualified by instr_valid and cpu_ready.
REQ-012 SHALL have port jump_addr, input, 8: redirect target.
REQ-013 SHALL have port halt, input, 1: level request to stop fetching.
REQ-014 SHALL have port dbg_req, input, 1: debug read request, held until dbg_valid.
REQ-015 SHALL have port dbg_addr, input, 8: debug read address, stable while dbg_req=1.
REQ-016 SHALL have port dbg_data, output, 35: registered debug read data.
REQ-017 SHALL have port dbg_valid, output, 1: one-cycle pulse; dbg_data is valid.

Function
REQ-018 SHALL implement FSM states RUN, HALTED, where HALTED is entered on the edge at which halt=1 and returns to RUN on the edge at which halt=0.
REQ-019 SHALL make fetch_slot=1 when state=RUN, halt=0, and (instr_valid=0 or cpu_ready=1).
REQ-020 SHALL compute grant (combinational) = dbg_req and dbg_valid=0 and (fetch_slot=0 or starve_cnt>=STARVE_MAX).
REQ-021 SHALL drive rom_addr = dbg_addr when grant=1, jump_addr when jump_take=1, and pc otherwise, where jump_take = jump_en and instr_valid and cpu_ready.
REQ-022 SHALL, on a fetch (fetch_slot=1 and grant=0), load instr<=rom_data, set instr_pc<=rom_addr, set instr_valid<=1, and set pc<=rom_addr+1 (8-bit wrap: 255 to 0).
REQ-023 SHALL, on jump_take with a fetch, fetch from jump_addr in the same cycle (zero-bubble redirect) and set pc<=jump_addr+1.
REQ-024 SHALL, on jump_take without a fetch (grant steal or halt), set pc<=jump_addr and instr_valid<=0.
REQ-025 SHALL, on consumption (instr_valid and cpu_ready) without a fetch, set instr_valid<=0 and leave pc unchanged.
REQ-026 SHALL, when instr_valid=1 and cpu_ready=0, hold instr, instr_pc and pc stable.
REQ-027 SHALL, in HALTED, perform no fetches, still honour consumption and jumps per REQ-024/025, and leave the ROM fully available to debug.
REQ-028 SHALL, on grant, set dbg_data<=rom_data and dbg_valid<=1 for exactly one cycle; no back-to-back grants (dbg_valid=1 blocks grant).
REQ-029 SHALL make starve_cnt a 3-bit saturating counter: increment when dbg_req=1 and grant=0 and dbg_valid=0; clear on grant or dbg_req=0.
REQ-030 SHALL give a steal (grant while fetch_slot=1) priority over the fetch; the consumption still occurs (instr_valid<=0), and the pending fetch retries next cycle.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, dbg_data=0, dbg_valid=0, starve_cnt=0, state=RUN.
REQ-032 SHALL, at the first edge after reset release with halt=0, fetch from RESET_PC; a reset mid-operation discards all in-flight state, including pending debug grants.

Verification
REQ-033 SHALL cover: reset release, cpu_ready=1, ROM[0..3] distinct -> instr_valid high from cycle 1, instr_pc = 0,1,2,3 on consecutive cycles.
REQ-034 SHALL cover: cpu_ready=0 for 3 cycles at instr_pc=4 -> instr and pc stable; after release, instr_pc=5 the next cycle.
REQ-035 SHALL cover: jump_en=1, jump_addr=20 while consuming instr_pc=12 -> the next instr_pc=20, then 21, with no bubble.
REQ-036 SHALL cover: pc=255 streaming -> instr_pc 255 then 0.
REQ-037 SHALL cover: dbg_req with dbg_addr=16 under continuous fetch -> grant after 4 denied cycles, dbg_valid pulse with dbg_data=ROM[16], and one fetch bubble.
REQ-038 SHALL cover: halt=1, then dbg_req -> grant on the first eligible cycle with no fetches; halt=0 resumes at the held pc.
